// File: rtl/srl_fifo_ctrl.sv
// Control plane for an external shift-register FIFO: tracks level and read address,
// drives the storage shift enable and presents ap_fifo full_n/empty_n handshake.
module srl_fifo_ctrl #(
    parameter int DATA_WIDTH        = 1,
    parameter int ADDR_WIDTH        = 1,
    parameter int DEPTH             = 2,
    parameter int ALMOST_FULL_LEVEL = 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    output logic                  if_almost_full_n,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    input  logic                  clear,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  sr_we,
    output logic [ADDR_WIDTH-1:0] sr_addr,
    output logic [DATA_WIDTH-1:0] sr_din,
    input  logic [DATA_WIDTH-1:0] sr_dout
);

    localparam logic [ADDR_WIDTH:0] LVL_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] LVL_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LVL_AF    = (ADDR_WIDTH+1)'(ALMOST_FULL_LEVEL);

    logic [ADDR_WIDTH:0]   r_level;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_full_n;
    logic                  r_empty_n;
    logic                  r_afull_n;

    logic                  w_push;
    logic                  w_pop;
    logic [ADDR_WIDTH:0]   w_next_level;
    logic [ADDR_WIDTH-1:0] w_next_addr;

    // Gating with ap_rst_n keeps sr_we low during reset, before the flags are known.
    assign w_push = if_write & r_full_n  & ap_rst_n;
    assign w_pop  = if_read  & r_empty_n & ap_rst_n;

    always_comb begin
        w_next_level = r_level;
        if (clear)
            w_next_level = '0;
        else if (w_push && !w_pop)
            w_next_level = r_level + LVL_ONE;
        else if (w_pop && !w_push)
            w_next_level = r_level - LVL_ONE;
    end

    // Oldest word sits at level-1; the address parks at 0 when empty.
    always_comb begin
        w_next_addr = '0;
        if (w_next_level != '0)
            w_next_addr = ADDR_WIDTH'(w_next_level - LVL_ONE);
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_level   <= '0;
            r_addr    <= '0;
            r_empty_n <= 1'b0;
            r_full_n  <= 1'b1;
            r_afull_n <= 1'b1;
        end else begin
            r_level   <= w_next_level;
            r_addr    <= w_next_addr;
            r_empty_n <= (w_next_level != '0);
            r_full_n  <= (w_next_level != LVL_DEPTH);
            r_afull_n <= (w_next_level < LVL_AF);
        end
    end

    assign sr_we            = w_push;
    assign sr_din           = if_din;
    assign sr_addr          = r_addr;
    assign if_dout          = sr_dout;
    assign level            = r_level;
    assign if_empty_n       = r_empty_n;
    assign if_full_n        = r_full_n;
    assign if_almost_full_n = r_afull_n;

endmodule
